// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal slices, one register each.
// Define PIPE_ADDSUB_SAT_EN to clamp the result on signed overflow (cout/ovf still report the raw sum).
module pipe_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             adv;
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];

  // The whole pipeline moves as one: it only freezes when the last stage is blocked.
  assign adv      = !vld_q[LAST] || out_ready;
  assign in_ready = adv;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             vld_in;
    logic             cy_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bx_in;
    logic [WIDTH-1:0] s_in;
    logic [SW:0]      slice_sum;
    logic             vld_d;
    logic             cy_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] bx_d;
    logic [WIDTH-1:0] s_d;

    if (gi == 0) begin : g_src
      assign vld_in = in_valid && adv;
      assign cy_in  = sub;
      assign a_in   = a;
      assign bx_in  = b ^ {WIDTH{sub}};
      assign s_in   = '0;
    end else begin : g_src
      assign vld_in = vld_q[gi-1];
      assign cy_in  = cy_q[gi-1];
      assign a_in   = a_q[gi-1];
      assign bx_in  = bx_q[gi-1];
      assign s_in   = s_q[gi-1];
    end

    always_comb begin
      slice_sum = {1'b0, a_in[gi*SW +: SW]} + {1'b0, bx_in[gi*SW +: SW]}
                + {{SW{1'b0}}, cy_in};
      vld_d     = vld_in;
      cy_d      = slice_sum[SW];
      a_d       = a_in;
      bx_d      = bx_in;
      s_d       = s_in;
      s_d[gi*SW +: SW] = slice_sum[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[gi] <= 1'b0;
        cy_q[gi]  <= 1'b0;
        a_q[gi]   <= '0;
        bx_q[gi]  <= '0;
        s_q[gi]   <= '0;
      end else if (adv) begin
        vld_q[gi] <= vld_d;
        cy_q[gi]  <= cy_d;
        a_q[gi]   <= a_d;
        bx_q[gi]  <= bx_d;
        s_q[gi]   <= s_d;
      end
    end
  end

  logic a_msb;
  logic ovf_raw;

  always_comb begin
    a_msb     = a_q[LAST][WIDTH-1];
    ovf_raw   = (a_msb == bx_q[LAST][WIDTH-1]) && (s_q[LAST][WIDTH-1] != a_msb);
    out_valid = vld_q[LAST];
    cout      = cy_q[LAST];
    ovf       = ovf_raw;
    s         = s_q[LAST];
`ifdef PIPE_ADDSUB_SAT_EN
    // Overflow direction follows the sign of A: positive clamps to 011..1, negative to 100..0.
    if (ovf_raw) begin
      s = {a_msb, {(WIDTH-1){!a_msb}}};
    end
`endif
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed 8-bit vectors, backpressure and reset
// sequences, and randomized sweeps on 32/4 and 16/1 configurations against a reference model.
module tb_pipe_addsub;
`ifdef PIPE_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_c, out_ready_c, sub_c;
  logic [31:0] a_c, b_c;
  logic [1:0]  sel;

  logic        iv8, ir8, ov8, or8, c8, o8;
  logic [7:0]  s8;
  logic        iv32, ir32, ov32, or32, c32, o32;
  logic [31:0] s32;
  logic        iv16, ir16, ov16, or16, c16, o16;
  logic [15:0] s16;

  logic        ov_m, ir_m, c_m, o_m;
  logic [31:0] s_m;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign iv8  = in_valid_c && (sel == 2'd0);
  assign iv32 = in_valid_c && (sel == 2'd1);
  assign iv16 = in_valid_c && (sel == 2'd2);
  assign or8  = out_ready_c || (sel != 2'd0);
  assign or32 = out_ready_c || (sel != 2'd1);
  assign or16 = out_ready_c || (sel != 2'd2);

  pipe_addsub #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a_c[7:0]), .b(b_c[7:0]),
    .sub(sub_c), .out_valid(ov8), .out_ready(or8), .s(s8), .cout(c8), .ovf(o8));
  pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a_c), .b(b_c),
    .sub(sub_c), .out_valid(ov32), .out_ready(or32), .s(s32), .cout(c32), .ovf(o32));
  pipe_addsub #(.WIDTH(16), .STAGES(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a_c[15:0]), .b(b_c[15:0]),
    .sub(sub_c), .out_valid(ov16), .out_ready(or16), .s(s16), .cout(c16), .ovf(o16));

  always_comb begin
    ov_m = ov8; ir_m = ir8; s_m = {24'b0, s8}; c_m = c8; o_m = o8;
    case (sel)
      2'd1: begin ov_m = ov32; ir_m = ir32; s_m = s32; c_m = c32; o_m = o32; end
      2'd2: begin ov_m = ov16; ir_m = ir16; s_m = {16'b0, s16}; c_m = c16; o_m = o16; end
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input int w);
    res_t        r;
    logic [31:0] mask;
    logic [31:0] bx;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bx   = (sub ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bx} + {32'b0, sub};
    r.s  = full[31:0] & mask;
    r.c  = full[w];
    r.o  = (a[w-1] == bx[w-1]) && (r.s[w-1] != a[w-1]);
    if (SAT && r.o) r.s = a[w-1] ? (32'd1 << (w-1)) : ((32'd1 << (w-1)) - 32'd1);
    return r;
  endfunction

  // One isolated operation on the selected DUT; latency counts edges from the accepting edge.
  task automatic single(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                        input int exp_lat, input logic [31:0] es, input logic ec,
                        input logic eo, input string nm);
    int lat;
    out_ready_c = 1'b1;
    @(posedge clk); #1;
    a_c = ai; b_c = bi; sub_c = si; in_valid_c = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid_c = 1'b0;
    end while (!ov_m && lat < 20);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " s"}, s_m, es);
    chk({nm, " cout"}, c_m, ec);
    chk({nm, " ovf"}, o_m, eo);
  endtask

  task automatic backpressure();
    int          exp_s[4] = '{2, 4, 6, 8};
    int          idx = 0, got = 0, stalls = 0, cyc = 0;
    logic [31:0] held = '0;
    sel = 2'd0; out_ready_c = 1'b1; in_valid_c = 1'b0;
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      in_valid_c = (idx < 4);
      a_c = idx + 1; b_c = idx + 1; sub_c = 1'b0;
      if (ov_m && stalls < 3) begin
        if (stalls == 0) held = s_m;
        out_ready_c = 1'b0;
        stalls++;
      end else begin
        out_ready_c = 1'b1;
      end
      @(negedge clk);
      if (!out_ready_c) begin
        chk("stall in_ready", ir_m, 0);
        chk("stall out_valid", ov_m, 1);
        chk("stall s held", s_m, held);
      end
      if (in_valid_c && ir_m) idx++;
      if (ov_m && out_ready_c) begin
        chk($sformatf("bp result%0d", got), s_m, exp_s[got]);
        got++;
      end
    end
    chk("bp delivered", got, 4);
    chk("bp accepted", idx, 4);
    chk("bp stall cycles", stalls, 3);
    in_valid_c = 1'b0; out_ready_c = 1'b1;
  endtask

  task automatic sweep(input int w, input int n);
    res_t        q[$];
    res_t        e;
    logic [31:0] mask;
    logic [31:0] corners[4];
    int          acc = 0, got = 0, cyc = 0;
    logic        acc_pend = 1'b0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    corners = '{32'h00FF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    in_valid_c = 1'b0;
    while (got < n && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_pend || !in_valid_c) begin
        if (acc < n) begin
          in_valid_c = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 7) == 0) begin
            a_c = corners[$urandom_range(0, 3)] & mask;
            b_c = 32'd1;
          end else begin
            a_c = $urandom & mask;
            b_c = $urandom & mask;
          end
          sub_c = 1'($urandom_range(0, 1));
        end else begin
          in_valid_c = 1'b0;
        end
      end
      out_ready_c = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_pend = in_valid_c && ir_m;
      if (acc_pend) begin
        q.push_back(model(a_c, b_c, sub_c, w));
        acc++;
      end
      if (ov_m && out_ready_c) begin
        if (q.size() == 0) begin
          chk($sformatf("w%0d spurious result", w), ov_m, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("w%0d op%0d {s,cout,ovf}", w, got), {s_m, c_m, o_m}, e);
        end
        got++;
      end
    end
    chk($sformatf("w%0d results delivered", w), got, n);
    in_valid_c = 1'b0; out_ready_c = 1'b1;
  endtask

  initial begin
    vec_t tv[12];
    int   lat;
    int   stale;
    tv[0]  = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    tv[1]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tv[2]  = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    tv[3]  = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
    tv[4]  = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
    tv[5]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tv[6]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[7]  = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
    tv[8]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[9]  = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    tv[10] = '{8'h40, 8'h40, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
    tv[11] = '{8'h80, 8'h7F, 1'b1, SAT ? 8'h80 : 8'h01, 1'b1, 1'b1};

    rst = 1'b1; in_valid_c = 1'b0; out_ready_c = 1'b1;
    a_c = '0; b_c = '0; sub_c = 1'b0; sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid8", ov8, 0);
    chk("reset s8", s8, 0);
    chk("reset cout8", c8, 0);
    chk("reset ovf8", o8, 0);
    chk("reset out_valid32", ov32, 0);
    chk("reset s32", s32, 0);
    chk("reset out_valid16", ov16, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      single({24'b0, tv[i].a}, {24'b0, tv[i].b}, tv[i].sub, 2, {24'b0, tv[i].s}, tv[i].c,
             tv[i].o, $sformatf("vec%0d", i));

    backpressure();

    // Reset while a result with ovf=1 is being held: outputs must clear at once.
    sel = 2'd0;
    @(posedge clk); #1;
    out_ready_c = 1'b0; a_c = 32'h7F; b_c = 32'h01; sub_c = 1'b0; in_valid_c = 1'b1;
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    lat = 0;
    while (!ov_m && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("pre-reset out_valid", ov_m, 1);
    chk("pre-reset ovf", o_m, 1);
    rst = 1'b1; #1;
    chk("async reset out_valid", ov8, 0);
    chk("async reset s", s8, 0);
    chk("async reset ovf", o8, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready_c = 1'b1;
    stale = 0;
    repeat (4) begin @(negedge clk); if (ov8) stale++; end
    chk("no stale after reset8", stale, 0);

    sel = 2'd1;
    single(32'h00FF_FFFF, 32'h1, 1'b0, 4, 32'h0100_0000, 1'b0, 1'b0, "w32 carry");
    single(32'h0100_0000, 32'h1, 1'b1, 4, 32'h00FF_FFFF, 1'b1, 1'b0, "w32 borrow");

    // Two operations in flight in the 4-stage pipe, reset before either emerges.
    @(posedge clk); #1;
    out_ready_c = 1'b1; a_c = 32'd10; b_c = 32'd20; sub_c = 1'b0; in_valid_c = 1'b1;
    @(posedge clk); #1;
    a_c = 32'd30; b_c = 32'd40;
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midflight reset out_valid", ov32, 0);
    @(posedge clk); #1;
    rst = 1'b0; a_c = 32'd50; b_c = 32'd60; in_valid_c = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid_c = 1'b0;
    end while (!ov32 && lat < 20);
    chk("post-reset latency", lat, 4);
    chk("post-reset s", s32, 32'd110);
    @(posedge clk); #1;
    stale = 0;
    repeat (6) begin @(negedge clk); if (ov32) stale++; end
    chk("no stale after reset32", stale, 0);

    sweep(32, 1000);

    sel = 2'd2;
    single(32'h0000_FFFF, 32'h1, 1'b0, 1, 32'h0, 1'b1, 1'b0, "w16 wrap");
    single(32'h0000_7FFF, 32'h1, 1'b0, 1, SAT ? 32'h7FFF : 32'h8000, 1'b0, 1'b1, "w16 ovf");
    sweep(16, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d passed of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined adder/subtractor with valid/ready handshakes. It replaces the fixed 8-bit combinational ripple adder wherever operands arrive as a stream. The carry chain is split into `STAGES` equal slices, with one register per slice, so the block sustains one operation per clock at any width. It reports carry-out and signed overflow. An optional mode clamps results on signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥2.
- `STAGES`, default 2: pipeline depth and number of carry-chain slices.
  - Must be ≥1, and `WIDTH % STAGES == 0`.
  - Slice width is `SW = WIDTH/STAGES`.
- `clk`, input, 1: the only clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operand set presented.
- `in_ready`, output, 1: block accepts operands this cycle.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `sub`, input, 1: 0 computes A+B; 1 computes A−B.
- `out_valid`, output, 1: result presented.
- `out_ready`, input, 1: consumer accepts the result.
- `s`, output, WIDTH: result.
- `cout`, output, 1: carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf`, output, 1: two's-complement signed overflow.

## Operation
- **Arithmetic:**
  - Result is `a + (sub ? ~b : b) + sub`, computed modulo 2^WIDTH.
  - `cout` is bit WIDTH of the unclamped sum.
  - `ovf = (a[W-1] == b'[W-1]) && (s_raw[W-1] != a[W-1])`, where `b'` is `b` after conditional inversion.
- **Slicing:**
  - Stage k (0..STAGES−1) adds bits `[k*SW +: SW]` using the carry registered by stage k−1. Stage 0 uses `sub` as carry-in.
  - Operand bits for later slices are carried forward in skew registers alongside the data.
  - Result slices from earlier stages are carried forward unchanged.
- **Pipeline control:**
  - Each stage holds a valid bit. A global advance is `adv = !out_valid || out_ready`.
  - When `adv`=1, every stage loads from its predecessor. Stage 0 loads `in_valid && in_ready`.
  - When `adv`=0, all stages hold.
- **Input handshake:**
  - `in_ready = adv`, derived combinationally from `out_valid` and `out_ready`.
  - An operand transfer occurs when `in_valid && in_ready` is high at a rising edge.
- **Output handshake:**
  - `s`, `cout` and `ovf` are driven from the last-stage registers and are stable while `out_valid`=1 and `out_ready`=0.
  - A result is consumed when `out_valid && out_ready` is high at an edge.
- **Ordering:** results leave in acceptance order. No drops and no duplicates.
- **Bubbles:** invalid stages still shift when `adv`=1. Data in invalid stages is don't-care, but must not affect valid results.

## Timing
- **Reset state:** all stage valid bits, data, carry and skew registers clear to 0. While `rst` is high, `out_valid`=0, `s`=0, `cout`=0 and `ovf`=0.
- **Latency:** with no stall, a result appears with `out_valid`=1 exactly `STAGES` cycles after the accepting edge.
- **Throughput:** one operation per cycle while `out_ready`=1.
- **Stall:** when `out_valid`=1 and `out_ready`=0, `in_ready` is 0 in that same cycle and the pipeline freezes. Operands offered during a stall are not taken.
- **Simultaneous events:** a result being consumed and a new operand accepted on the same edge is a normal transfer.
- **Reset mid-operation:** asserting `rst` discards every in-flight operation immediately. After release, the first acceptance is possible on the first edge with `rst` low.
- **STAGES=1:** a single register stage with latency 1.

## Configuration
- `PIPE_ADDSUB_SAT_EN` defined:
  - When `ovf`=1, `s` is clamped to the signed limit: positive overflow gives `0111…1`, negative overflow gives `1000…0`.
  - The clamp is applied in the last stage with no added latency.
  - `cout` and `ovf` still report the unclamped result.
- `PIPE_ADDSUB_SAT_EN` undefined: `s` always wraps modulo 2^WIDTH.

## Test plan
- **Unsigned carry** (WIDTH=8, STAGES=2, sub=0): a=200, b=100 → after 2 cycles `s`=44, `cout`=1, `ovf`=0.
- **Subtraction with borrow** (sub=1): a=5, b=7 → `s`=0xFE, `cout`=0, `ovf`=0. Then a=7, b=5 → `s`=2, `cout`=1.
- **Signed overflow:** a=0x7F, b=0x01, sub=0 → `ovf`=1 and `cout`=0.
  - Without the macro, `s`=0x80.
  - With `PIPE_ADDSUB_SAT_EN`, `s`=0x7F.
  - a=0x80, b=0x01, sub=1 → `ovf`=1; `s` is 0x7F wrapped, and 0x80 saturated.
- **Backpressure:**
  - Stream 1+1, 2+2, 3+3, 4+4 back-to-back, and hold `out_ready`=0 for 3 cycles after the first `out_valid`.
  - Expect `in_ready`=0 during the stall and outputs held stable.
  - Then 2, 4, 6, 8 are delivered in order with no loss.
- **Reset mid-flight:** accept two operations, then pulse `rst` for one cycle before either emerges. Expect `out_valid`=0 immediately and no stale results afterwards.
- **Width sweep:** with WIDTH=32 and STAGES=4, and with WIDTH=16 and STAGES=1, run 1000 random operands with random `in_valid`/`out_ready`. Every result must match the reference model, and all carries crossing slice boundaries (e.g. 0x00FFFFFF + 1) must be correct.
